// File: rtl/channel_scan_sequencer_pkg.sv
// Shared definitions for the channel scan sequencer.
//   SEL_W_DEF / DWELL_W_DEF : default widths of the channel index and dwell input
//   state_t                 : scan FSM state encoding (ST_IDLE=0, ST_RUN=1)
package channel_scan_sequencer_pkg;

  localparam int SEL_W_DEF   = 3;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/channel_scan_sequencer_scan_next_sel.sv
// Circular next-set-bit search used to pick the next channel to scan.
// Ports:
//   cur     in  SEL_W  current channel index (search starts strictly after it)
//   mask    in  N_CH   1 = channel eligible
//   nxt     out SEL_W  first eligible channel after cur, wrapping around to cur itself
//   found   out 1      at least one eligible channel exists
//   wrapped out 1      the chosen index is not above cur (frame restarted)
module channel_scan_sequencer_scan_next_sel
  import channel_scan_sequencer_pkg::*;
#(
  parameter  int SEL_W = SEL_W_DEF,
  localparam int N_CH  = 2**SEL_W
) (
  input  logic [SEL_W-1:0] cur,
  input  logic [N_CH-1:0]  mask,
  output logic [SEL_W-1:0] nxt,
  output logic             found,
  output logic             wrapped
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = cur;
    // Walk from the farthest offset down to the nearest so the closest hit
    // is the one that sticks. Offset N_CH truncates to 0, i.e. cur itself,
    // which makes a single-bit mask reload the same channel.
    for (int i = N_CH; i >= 1; i--) begin
      idx = cur + SEL_W'(i);
      if (mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  assign wrapped = found && (nxt <= cur);

endmodule

// File: rtl/channel_scan_sequencer.sv
// Channel scan sequencer: drives a rotating channel index into a 3-to-8
// decoder, holding each channel for a programmable dwell time.
// Build option: define SCAN_SKIP_EN to skip channels whose ch_mask bit is 0;
// without it ch_mask is ignored and the sequence is strictly 0..N_CH-1.
// Ports:
//   clk       in  1        rising-edge clock
//   rst       in  1        asynchronous active-high reset
//   start     in  1        begin scanning (honoured only when idle)
//   stop      in  1        halt at the end of the current dwell
//   dwell     in  DWELL_W  cycles per channel (0 behaves as 1), sampled at each load
//   ch_mask   in  N_CH     channel enables (SCAN_SKIP_EN only)
//   sel       out SEL_W    channel index
//   sel_valid out 1        sel is a live channel
//   tick      out 1        one-cycle pulse on every channel load
//   wrap      out 1        one-cycle pulse when a load restarts the frame
//   busy      out 1        scanning, including a pending stop
module channel_scan_sequencer
  import channel_scan_sequencer_pkg::*;
#(
  parameter  int SEL_W   = SEL_W_DEF,
  parameter  int DWELL_W = DWELL_W_DEF,
  localparam int N_CH    = 2**SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [N_CH-1:0]    ch_mask,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               tick,
  output logic               wrap,
  output logic               busy
);

  // Counter reload value: max(dwell,1)-1.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               stop_pend_q, stop_pend_d;

  logic [N_CH-1:0]    eff_mask;
  logic [SEL_W-1:0]   search_cur;
  logic [SEL_W-1:0]   nxt_sel;
  logic               nxt_found;
  logic               nxt_wrapped;

`ifdef SCAN_SKIP_EN
  assign eff_mask = ch_mask;
`else
  logic unused_ch_mask;
  assign unused_ch_mask = ^ch_mask;
  assign eff_mask       = '1;
`endif

  // From idle, searching after the top index lands on the lowest eligible channel.
  assign search_cur = (state_q == ST_IDLE) ? {SEL_W{1'b1}} : sel_q;

  channel_scan_sequencer_scan_next_sel #(
    .SEL_W (SEL_W)
  ) u_next_sel (
    .cur     (search_cur),
    .mask    (eff_mask),
    .nxt     (nxt_sel),
    .found   (nxt_found),
    .wrapped (nxt_wrapped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      valid_q     <= 1'b0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    tick_d      = 1'b0;
    wrap_d      = 1'b0;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop && nxt_found) begin
          state_d     = ST_RUN;
          sel_d       = nxt_sel;
          valid_d     = 1'b1;
          tick_d      = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = dwell_load(dwell);
          stop_pend_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          // A stop arriving on the final dwell cycle still halts here.
          if (stop_pend_q || stop || !nxt_found) begin
            state_d     = ST_IDLE;
            sel_d       = '0;
            valid_d     = 1'b0;
            busy_d      = 1'b0;
            cnt_d       = '0;
            stop_pend_d = 1'b0;
          end else begin
            sel_d  = nxt_sel;
            tick_d = 1'b1;
            wrap_d = nxt_wrapped;
            cnt_d  = dwell_load(dwell);
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
          if (stop) begin
            stop_pend_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sel       = sel_q;
  assign sel_valid = valid_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;
  assign busy      = busy_q;

endmodule
